// File: rtl/fifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ptr_ctrl
//
// Read-side pointer and status controller of an asynchronous FIFO. Runs
// entirely in the read clock domain. Keeps the read pointer in binary and Gray
// form. Compares it with the already-synchronized Gray write pointer to produce
// registered empty / almost-empty / fill-level flags, plus read-acknowledge and
// underflow pulses.
//
// Ports:
//   rd_clk_i        read-domain clock
//   rst_i           asynchronous active-high reset
//   rd_en_i         read request from the consumer
//   wp2rp_gray_i    synchronized Gray write pointer (PTR_WIDTH+1 bits)
//   rptr_gray_o     registered Gray read pointer, to the read->write synchronizer
//   raddr_o         RAM read address (low PTR_WIDTH bits of the binary pointer)
//   empty_o         FIFO empty (registered)
//   almost_empty_o  fill level <= ALMOST_EMPTY_TH (registered)
//   rd_level_o      words available, 0..2^PTR_WIDTH (registered)
//   rd_ack_o        one-cycle pulse after an accepted read (RAM data valid)
//   underflow_o     one-cycle pulse after a read request while empty
// -----------------------------------------------------------------------------
module fifo_rd_ptr_ctrl #(
  parameter int PTR_WIDTH       = 5,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                 rd_clk_i,
  input  logic                 rst_i,
  input  logic                 rd_en_i,
  input  logic [PTR_WIDTH:0]   wp2rp_gray_i,
  output logic [PTR_WIDTH:0]   rptr_gray_o,
  output logic [PTR_WIDTH-1:0] raddr_o,
  output logic                 empty_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   rd_level_o,
  output logic                 rd_ack_o,
  output logic                 underflow_o
);

  // Threshold resized to the pointer width so the compare below is exact.
  localparam logic [PTR_WIDTH:0] AE_TH = (PTR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [PTR_WIDTH:0] rbin_reg;
  logic [PTR_WIDTH:0] rbin_next;
  logic [PTR_WIDTH:0] rgray_reg;
  logic [PTR_WIDTH:0] rgray_next;
  logic               empty_reg;
  logic               empty_next;
  logic               almost_empty_reg;
  logic               almost_empty_next;
  logic [PTR_WIDTH:0] level_reg;
  logic [PTR_WIDTH:0] level_next;
  logic               ack_reg;
  logic               underflow_reg;
  logic               rd_acc;
  logic [PTR_WIDTH:0] wbin;

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi <= PTR_WIDTH; gi++) begin : g_gray2bin
      assign wbin[gi] = ^(wp2rp_gray_i >> gi);
    end
  endgenerate

  // Reads are gated by the registered empty flag, so a read that drains the
  // last word cannot be followed by a second read based on stale status.
  assign rd_acc     = rd_en_i & ~empty_reg;
  assign rbin_next  = rbin_reg + {{PTR_WIDTH{1'b0}}, rd_acc};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);

  // Status is computed from the post-read pointer. The write pointer lags
  // (it comes through a synchronizer), so these flags can only be pessimistic.
  assign empty_next        = (rgray_next == wp2rp_gray_i);
  assign level_next        = wbin - rbin_next;
  assign almost_empty_next = (level_next <= AE_TH);

  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rbin_reg         <= '0;
      rgray_reg        <= '0;
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b1;
      level_reg        <= '0;
      ack_reg          <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      rbin_reg         <= rbin_next;
      rgray_reg        <= rgray_next;
      empty_reg        <= empty_next;
      almost_empty_reg <= almost_empty_next;
      level_reg        <= level_next;
      ack_reg          <= rd_acc;
      underflow_reg    <= rd_en_i & empty_reg;
    end
  end

  // The Gray pointer leaves the domain straight from a flop, so the
  // downstream synchronizer never sees a combinational glitch.
  assign rptr_gray_o    = rgray_reg;
  assign raddr_o        = rbin_reg[PTR_WIDTH-1:0];
  assign empty_o        = empty_reg;
  assign almost_empty_o = almost_empty_reg;
  assign rd_level_o     = level_reg;
  assign rd_ack_o       = ack_reg;
  assign underflow_o    = underflow_reg;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ptr_ctrl
//
// Self-checking bench for fifo_rd_ptr_ctrl. The reference is a word-count
// model: total writes published vs. total reads accepted, as plain integers.
// Every expected output is derived from those two counts. A compare process
// checks all outputs on each falling edge. Directed phases add literal checks
// that pin the model. A randomized phase then exercises full and empty
// boundaries.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ptr_ctrl;

  localparam int PW    = 5;
  localparam int DEPTH = 32;
  localparam int TH    = 2;

  logic          rd_clk_i = 1'b0;
  logic          rst_i    = 1'b1;
  logic          rd_en_i  = 1'b1;
  logic [PW:0]   wp2rp_gray_i;
  logic [PW:0]   rptr_gray_o;
  logic [PW-1:0] raddr_o;
  logic          empty_o;
  logic          almost_empty_o;
  logic [PW:0]   rd_level_o;
  logic          rd_ack_o;
  logic          underflow_o;

  int n_cmp = 0;
  int n_err = 0;

  // Total write-pointer count presented to the DUT (already "synchronized").
  int wr_total = 0;

  function automatic logic [PW:0] gray_of(input int v);
    logic [PW:0] b;
    b = v[PW:0];
    return b ^ (b >> 1);
  endfunction

  assign wp2rp_gray_i = gray_of(wr_total);

  fifo_rd_ptr_ctrl #(.PTR_WIDTH(PW), .ALMOST_EMPTY_TH(TH)) dut (
    .rd_clk_i       (rd_clk_i),
    .rst_i          (rst_i),
    .rd_en_i        (rd_en_i),
    .wp2rp_gray_i   (wp2rp_gray_i),
    .rptr_gray_o    (rptr_gray_o),
    .raddr_o        (raddr_o),
    .empty_o        (empty_o),
    .almost_empty_o (almost_empty_o),
    .rd_level_o     (rd_level_o),
    .rd_ack_o       (rd_ack_o),
    .underflow_o    (underflow_o)
  );

  always #5 rd_clk_i = ~rd_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word counts) ----------------
  int m_rd    = 0;  // total reads accepted
  int m_level = 0;  // words available as seen by the read side
  bit m_empty = 1'b1;
  bit m_ack   = 1'b0;
  bit m_unf   = 1'b0;
  bit m_take;

  assign m_take = rd_en_i && !m_empty;

  always @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_rd    <= 0;
      m_level <= 0;
      m_empty <= 1'b1;
      m_ack   <= 1'b0;
      m_unf   <= 1'b0;
    end else begin
      m_rd    <= m_rd + (m_take ? 1 : 0);
      m_level <= wr_total - m_rd - (m_take ? 1 : 0);
      m_empty <= (wr_total - m_rd - (m_take ? 1 : 0)) == 0;
      m_ack   <= m_take;
      m_unf   <= rd_en_i && m_empty;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge rd_clk_i) begin
    if (!rst_i) begin
      chk("empty",        32'(empty_o),        32'(m_empty));
      chk("level",        32'(rd_level_o),     m_level);
      chk("almost_empty", 32'(almost_empty_o), (m_level <= TH) ? 32'd1 : 32'd0);
      chk("rptr_gray",    32'(rptr_gray_o),    32'(gray_of(m_rd)));
      chk("raddr",        32'(raddr_o),        m_rd % DEPTH);
      chk("rd_ack",       32'(rd_ack_o),       32'(m_ack));
      chk("underflow",    32'(underflow_o),    32'(m_unf));
      if (rd_ack_o)
        $display("read: addr=%0d rptr_gray=%0h level=%0d", (m_rd - 1) % DEPTH, rptr_gray_o, rd_level_o);
    end
  end

  // ---------------- stimulus ----------------
  int acks, unfs, cyc;
  int rdp[3] = '{50, 20, 80};
  int wrp[3] = '{80, 40, 50};

  initial begin
    // Reset held with a read request pending.
    repeat (3) @(posedge rd_clk_i);
    #1;
    chk("rst_rptr",  32'(rptr_gray_o),    32'd0);
    chk("rst_empty", 32'(empty_o),        32'd1);
    chk("rst_ae",    32'(almost_empty_o), 32'd1);
    chk("rst_level", 32'(rd_level_o),     32'd0);
    chk("rst_unf",   32'(underflow_o),    32'd0);
    @(negedge rd_clk_i) rst_i = 1'b0;
    repeat (3) @(posedge rd_clk_i);
    #1;
    chk("empty_unf_pulse", 32'(underflow_o), 32'd1);
    chk("empty_rptr_hold", 32'(rptr_gray_o), 32'd0);

    // Write pointer Gray 1,3,2,6,7, no reads.
    @(negedge rd_clk_i) rd_en_i = 1'b0;
    @(negedge rd_clk_i) wr_total = 1;
    @(posedge rd_clk_i); #1;
    chk("empty_deassert", 32'(empty_o), 32'd0);
    for (int k = 2; k <= 5; k++) @(negedge rd_clk_i) wr_total = k;
    @(posedge rd_clk_i); #1;
    chk("level5",    32'(rd_level_o),     32'd5);
    chk("level5_ae", 32'(almost_empty_o), 32'd0);

    // Six read requests against five words.
    acks = 0; unfs = 0;
    @(negedge rd_clk_i) rd_en_i = 1'b1;
    repeat (6) begin
      @(posedge rd_clk_i); #1;
      acks += int'(rd_ack_o);
      unfs += int'(underflow_o);
    end
    @(negedge rd_clk_i) rd_en_i = 1'b0;
    chk("drain_acks",  acks, 32'd5);
    chk("drain_unfs",  unfs, 32'd1);
    chk("drain_rptr",  32'(rptr_gray_o), 32'd7);
    chk("drain_empty", 32'(empty_o),     32'd1);
    @(posedge rd_clk_i); #1;
    chk("drain_rptr_hold", 32'(rptr_gray_o), 32'd7);

    // Wrap through rbin 31 -> 32 up to 40.
    cyc = 0;
    @(negedge rd_clk_i) rd_en_i = 1'b1;
    while (m_rd != 40 && cyc < 200) begin
      if (wr_total < 40) wr_total++;
      @(negedge rd_clk_i);
      cyc++;
    end
    rd_en_i = 1'b0;
    chk("wrap_reached", 32'(m_rd == 40), 32'd1);
    @(posedge rd_clk_i); #1;
    chk("wrap_rptr",  32'(rptr_gray_o), 32'd60);
    chk("wrap_raddr", 32'(raddr_o),     32'd8);
    chk("wrap_empty", 32'(empty_o),     32'd1);

    // Simultaneous read and write at level 2.
    @(negedge rd_clk_i) wr_total = 41;
    @(negedge rd_clk_i) wr_total = 42;
    repeat (2) @(negedge rd_clk_i);
    rd_en_i  = 1'b1;
    wr_total = 43;
    @(posedge rd_clk_i); #1;
    chk("simul_level", 32'(rd_level_o),     32'd2);
    chk("simul_ae",    32'(almost_empty_o), 32'd1);
    chk("simul_empty", 32'(empty_o),        32'd0);
    chk("simul_ack",   32'(rd_ack_o),       32'd1);
    @(negedge rd_clk_i) rd_en_i = 1'b0;

    // Randomized traffic, never overfilling the FIFO.
    for (int p = 0; p < 3; p++) begin
      repeat (700) begin
        @(negedge rd_clk_i);
        rd_en_i = ($urandom_range(99) < rdp[p]);
        if ($urandom_range(99) < wrp[p] && (wr_total - m_rd) < DEPTH)
          wr_total++;
      end
    end

    // Reset mid-burst at level 10.
    cyc = 0;
    @(negedge rd_clk_i) rd_en_i = 1'b1;
    while ((wr_total - m_rd) > 10 && cyc < 100) begin
      @(negedge rd_clk_i);
      cyc++;
    end
    rd_en_i = 1'b0;
    cyc = 0;
    while ((wr_total - m_rd) < 10 && cyc < 100) begin
      wr_total++;
      @(negedge rd_clk_i);
      cyc++;
    end
    chk("burst_level_reached", 32'(wr_total - m_rd), 32'd10);
    repeat (2) @(negedge rd_clk_i);
    rd_en_i = 1'b1;
    @(posedge rd_clk_i);
    @(posedge rd_clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_ack",   32'(rd_ack_o),       32'd0);
    chk("arst_empty", 32'(empty_o),        32'd1);
    chk("arst_level", 32'(rd_level_o),     32'd0);
    chk("arst_rptr",  32'(rptr_gray_o),    32'd0);
    chk("arst_raddr", 32'(raddr_o),        32'd0);
    chk("arst_ae",    32'(almost_empty_o), 32'd1);
    @(negedge rd_clk_i) wr_total = 0;
    @(negedge rd_clk_i) rst_i = 1'b0;
    acks = 0;
    repeat (3) begin
      @(posedge rd_clk_i); #1;
      acks += int'(rd_ack_o);
    end
    chk("post_rst_no_ack", acks, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
